// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared mode encodings and index-width helper for rr_mux_nx1
package rr_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Channel index width; a 2-channel mux still needs one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority grant with next pointer
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic [IW-1:0] next_ptr
);

  int          cand;
  logic        found;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    next_ptr  = ptr;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        if (mode == MODE_FIXED) begin
          cand = k;
        end else begin
          cand = int'(ptr) + k;
          if (cand >= N) cand = cand - N;
        end
        cand_idx = IW'(cand);
        if (!found && valid[cand_idx]) begin
          found           = 1'b1;
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
          // Fixed priority leaves the rotation point where round-robin left it
          if (mode == MODE_RR) begin
            next_ptr = (cand == N - 1) ? '0 : IW'(cand + 1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// rtl/rr_mux_nx1.sv - N:1 arbitrated mux with registered output; RR_MUX_NX1_SEL_OUT_EN adds m_sel
module rr_mux_nx1
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N*WIDTH-1:0]      in_data,
  input  logic [N-1:0]            in_valid,
  output logic [N-1:0]            in_ready,
  input  logic                    mode,
  output logic [WIDTH-1:0]        m_out,
  output logic                    m_valid,
  input  logic                    m_ready
`ifdef RR_MUX_NX1_SEL_OUT_EN
  ,
  output logic [idx_width(N)-1:0] m_sel
`endif
);

  localparam int IW = idx_width(N);

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    next_ptr;
  logic [IW-1:0]    grant_idx;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] sel_data;
  logic             can_load;
  logic             fire;

  assign can_load = !m_valid || m_ready;

  rr_arbiter #(.N(N), .IW(IW)) u_arbiter (
    .valid     (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .enable    (can_load && !reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .next_ptr  (next_ptr)
  );

  assign in_ready = grant;
  assign fire     = |grant;

  // Grant is one-hot, so an OR of masked channels is the mux
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) sel_data = sel_data | in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_out   <= '0;
      ptr     <= '0;
    end else if (can_load) begin
      m_valid <= fire;
      ptr     <= next_ptr;
      if (fire) m_out <= sel_data;
    end
  end

`ifdef RR_MUX_NX1_SEL_OUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      m_sel <= '0;
    end else if (can_load && fire) begin
      m_sel <= grant_idx;
    end
  end
`endif

endmodule

// File: doc/rr_mux_nx1.md
RR_MUX_NX1 -- requirements
Module: rr_mux_nx1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, as the data bits per channel.
REQ-002 The block SHALL have parameter N, default 4, as the input channel count; legal range 2..16, non-power-of-2 allowed.
REQ-003 The block SHALL have port clock  input  1  as the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  as a synchronous, active-high reset.
REQ-005 The block SHALL have port in_data  input  N*WIDTH  carrying channel k in bits [k*WIDTH +: WIDTH].
REQ-006 The block SHALL have port in_valid  input  N  as per-channel data valid.
REQ-007 The block SHALL have port in_ready  output  N  as per-channel accept, one-hot or zero.
REQ-008 The block SHALL have port mode  input  1  as arbitration mode: 0 round-robin, 1 fixed priority (lowest index wins).
REQ-009 The block SHALL have port m_out  output  WIDTH  as registered output data.
REQ-010 The block SHALL have port m_valid  output  1  as output data valid.
REQ-011 The block SHALL have port m_ready  input  1  as downstream accept.

Function
REQ-012 The block SHALL take can_load = !m_valid || m_ready; arbitration occurs only when can_load=1.
REQ-013 The block SHALL drive in_ready[g]=1 combinationally for granted channel g only, when can_load=1 and in_valid[g]=1; all other bits SHALL be 0.
REQ-014 On a cycle with in_valid[g] && in_ready[g], the block SHALL load m_out <= channel g data and set m_valid=1 at the next edge (latency 1 cycle).
REQ-015 When can_load=1 and no in_valid bit is set, the block SHALL clear m_valid at the next edge; m_out SHALL hold its value.
REQ-016 While m_valid=1 and m_ready=0, the block SHALL hold m_out and m_valid stable and keep in_ready=0.
REQ-017 When m_valid=1 and m_ready=1 in the same cycle as a new grant, the block SHALL replace the output with no bubble (full throughput, one transfer per cycle).
REQ-018 In round-robin mode, the block SHALL search from pointer ptr upward modulo N, and the first valid channel SHALL win.
REQ-019 After a grant to g in round-robin mode, the block SHALL set ptr <= (g+1) mod N; g=N-1 SHALL wrap to 0.
REQ-020 In fixed mode, the block SHALL grant the lowest-index valid channel and leave ptr unchanged.
REQ-021 The block SHALL apply a mode change on the next arbitration only; a held output SHALL be unaffected.
REQ-022 The block SHALL never grant a channel with in_valid=0, and ptr SHALL only change on a grant.

Reset
REQ-023 While reset=1 at an edge, the block SHALL set m_valid=0, m_out=0, ptr=0 (and m_sel=0 when present).
REQ-024 The block SHALL force in_ready=0 while reset=1.
REQ-025 Reset mid-transfer SHALL discard held output data with no completion signalled.

Configuration
REQ-026 With macro RR_MUX_NX1_SEL_OUT_EN defined, the block SHALL add port m_sel output clog2(N), registered alongside m_out, holding the index of the channel that produced m_out.
REQ-027 Without RR_MUX_NX1_SEL_OUT_EN, port m_sel and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package rr_mux_pkg SHALL hold the mode encodings (MODE_RR=0, MODE_FIXED=1) and the index-width function (clog2 of N, minimum 1).
REQ-029 The design SHALL use one sub-module, rr_arbiter, which maps (in_valid, ptr, mode, enable) to a one-hot grant and next ptr; the top holds only the datapath mux and output register.

Verification
REQ-030 Scenario: reset=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, m_valid=0, m_out=0, then first grant is channel 0.
REQ-031 Scenario: mode=0, in_valid=4'b1111 held, m_ready=1, channel k data=8'hA0+k -> m_out sequence A0,A1,A2,A3,A0 on consecutive cycles.
REQ-032 Scenario: mode=1, in_valid=4'b1010 -> only channel 1 is granted every cycle, and ptr is unchanged.
REQ-033 Scenario: m_ready=0 for 3 cycles with m_valid=1 -> m_out stable, in_ready=0; m_ready=1 -> next channel loads the same cycle.
REQ-034 Scenario: N=3, ptr at 2, in_valid=3'b011 -> grant channel 0 (wrap), next ptr=1.
REQ-035 Scenario: reset asserted while m_valid=1 and m_ready=0 -> next cycle m_valid=0, and the held data is never seen accepted.
